ov7670_config_sequencer: RTL and testbench

Reads the OV7670 register-init ROM word by word and turns each entry into one SCCB register write, a timed delay, or end-of-sequence. Sits between the synchronous config ROM (16-bit words {reg_addr, value}, 1-cycle registered read) and the SCCB write master. Reports busy/done/error to the top-level camera controller.

---
 rtl/ov7670_config_sequencer_if.sv | 27 ++
 rtl/ov7670_config_sequencer.sv | 152 +++++++++++++++
 tb/tb_ov7670_config_sequencer.sv | 309 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/ov7670_config_sequencer_if.sv
// rtl/ov7670_config_sequencer_if.sv - SCCB write-request handshake between config sequencer and SCCB master
interface ov7670_config_sequencer_if;
    logic       sccb_valid;
    logic       sccb_ready;
    logic [7:0] sccb_reg;
    logic [7:0] sccb_wdata;
    logic       sccb_done;
    logic       sccb_nack;

    modport master (
        output sccb_valid,
        output sccb_reg,
        output sccb_wdata,
        input  sccb_ready,
        input  sccb_done,
        input  sccb_nack
    );

    modport slave (
        input  sccb_valid,
        input  sccb_reg,
        input  sccb_wdata,
        output sccb_ready,
        output sccb_done,
        output sccb_nack
    );
endinterface

// File: rtl/ov7670_config_sequencer.sv
// rtl/ov7670_config_sequencer.sv - walks the OV7670 init ROM, issuing SCCB writes, timed delays and end-of-sequence
module ov7670_config_sequencer #(
    parameter int DELAY_CYCLES = 1_000_000,
    parameter int MAX_RETRY    = 3
) (
    input  logic                              clk,
    input  logic                              reset,
    input  logic                              start,
    output logic [7:0]                        rom_addr,
    input  logic [15:0]                       rom_data,
    ov7670_config_sequencer_if.master         sccb,
    output logic                              busy,
    output logic                              done,
    output logic                              error,
    output logic [7:0]                        write_count
);

    localparam int DW = $clog2(DELAY_CYCLES + 1);
    localparam int RW = (MAX_RETRY < 1) ? 1 : $clog2(MAX_RETRY + 1);

    localparam logic [DW-1:0] DELAY_LOAD  = DW'(DELAY_CYCLES - 1);
    localparam logic [RW-1:0] RETRY_LIMIT = RW'(MAX_RETRY);

    localparam logic [15:0] WORD_END   = 16'hFFFF;
    localparam logic [15:0] WORD_DELAY = 16'hFFF0;

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_FETCH  = 3'd1;
    localparam logic [2:0] S_DECODE = 3'd2;
    localparam logic [2:0] S_SEND   = 3'd3;
    localparam logic [2:0] S_WAIT   = 3'd4;
    localparam logic [2:0] S_DELAY  = 3'd5;
    localparam logic [2:0] S_DONE   = 3'd6;
    localparam logic [2:0] S_ERROR  = 3'd7;

    logic [2:0]    state;
    logic [RW-1:0] retry;
    logic [DW-1:0] delay_cnt;

    logic [2:0]    state_n;
    logic [7:0]    addr_n;
    logic          valid_n;
    logic [7:0]    reg_n;
    logic [7:0]    wdata_n;
    logic [7:0]    count_n;
    logic [RW-1:0] retry_n;
    logic [DW-1:0] delay_n;
    logic          advance;

    always_comb begin
        state_n = state;
        addr_n  = rom_addr;
        valid_n = sccb.sccb_valid;
        reg_n   = sccb.sccb_reg;
        wdata_n = sccb.sccb_wdata;
        count_n = write_count;
        retry_n = retry;
        delay_n = delay_cnt;
        advance = 1'b0;

        case (state)
            S_IDLE, S_DONE, S_ERROR: begin
                if (start) begin
                    state_n = S_FETCH;
                    addr_n  = 8'd0;
                    count_n = 8'd0;
                    retry_n = '0;
                end
            end
            S_FETCH: state_n = S_DECODE;
            S_DECODE: begin
                if (rom_data == WORD_END) begin
                    state_n = S_DONE;
                end else if (rom_data == WORD_DELAY) begin
                    state_n = S_DELAY;
                    delay_n = DELAY_LOAD;
                end else begin
                    reg_n   = rom_data[15:8];
                    wdata_n = rom_data[7:0];
                    valid_n = 1'b1;
                    state_n = S_SEND;
                end
            end
            S_SEND: begin
                if (sccb.sccb_ready) begin
                    valid_n = 1'b0;
                    state_n = S_WAIT;
                end
            end
            S_WAIT: begin
                if (sccb.sccb_done) begin
                    if (!sccb.sccb_nack) begin
                        if (write_count != 8'hFF) count_n = write_count + 8'd1;
                        retry_n = '0;
                        advance = 1'b1;
                    end else if (retry < RETRY_LIMIT) begin
                        // resend the same latched register/value
                        retry_n = retry + 1'b1;
                        valid_n = 1'b1;
                        state_n = S_SEND;
                    end else begin
                        state_n = S_ERROR;
                    end
                end
            end
            S_DELAY: begin
                if (delay_cnt == '0) advance = 1'b1;
                else                 delay_n = delay_cnt - 1'b1;
            end
            default: state_n = S_IDLE;
        endcase

        // the last ROM address finishes the run instead of wrapping to 0
        if (advance) begin
            if (rom_addr == 8'hFF) begin
                state_n = S_DONE;
            end else begin
                addr_n  = rom_addr + 8'd1;
                state_n = S_FETCH;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state           <= S_IDLE;
            rom_addr        <= 8'd0;
            sccb.sccb_valid <= 1'b0;
            sccb.sccb_reg   <= 8'd0;
            sccb.sccb_wdata <= 8'd0;
            write_count     <= 8'd0;
            retry           <= '0;
            delay_cnt       <= '0;
            busy            <= 1'b0;
            done            <= 1'b0;
            error           <= 1'b0;
        end else begin
            state           <= state_n;
            rom_addr        <= addr_n;
            sccb.sccb_valid <= valid_n;
            sccb.sccb_reg   <= reg_n;
            sccb.sccb_wdata <= wdata_n;
            write_count     <= count_n;
            retry           <= retry_n;
            delay_cnt       <= delay_n;
            busy            <= !((state_n == S_IDLE) || (state_n == S_DONE) || (state_n == S_ERROR));
            done            <= (state_n == S_DONE);
            error           <= (state_n == S_ERROR);
        end
    end

endmodule

// File: tb/tb_ov7670_config_sequencer.sv
// tb/tb_ov7670_config_sequencer.sv - self-checking bench for ov7670_config_sequencer
module tb_ov7670_config_sequencer;

    localparam int DELAY_CYCLES = 8;
    localparam int MAX_RETRY    = 3;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [7:0]  rom_addr;
    logic [15:0] rom_data;
    logic        busy;
    logic        done;
    logic        error;
    logic [7:0]  write_count;

    ov7670_config_sequencer_if sccb_bus ();

    ov7670_config_sequencer #(
        .DELAY_CYCLES (DELAY_CYCLES),
        .MAX_RETRY    (MAX_RETRY)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .start       (start),
        .rom_addr    (rom_addr),
        .rom_data    (rom_data),
        .sccb        (sccb_bus),
        .busy        (busy),
        .done        (done),
        .error       (error),
        .write_count (write_count)
    );

    always #5 clk = ~clk;

    logic [15:0] rom_mem [256];
    always @(posedge clk) rom_data <= rom_mem[rom_addr];

    int checks   = 0;
    int failures = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // reference model: expected write attempts with their latency (cycles from
    // the last start/sccb_done stimulus to sccb_valid becoming visible)
    typedef struct {
        logic [7:0] r;
        logic [7:0] d;
        int         lat;
    } txn_t;

    txn_t exp_q[$];
    bit   nack_plan[$];
    int   exp_wc, exp_addr, exp_end_lat;
    bit   exp_done, exp_err;

    function automatic void build_model();
        int          addr  = 0;
        int          lat   = 3;
        int          retry = 0;
        int          ni    = 0;
        bit          fin   = 0;
        logic [15:0] w;
        exp_q.delete();
        exp_wc   = 0;
        exp_done = 0;
        exp_err  = 0;
        while (!fin) begin
            w = rom_mem[addr];
            if (w == 16'hFFFF) begin
                exp_done = 1; exp_end_lat = lat; fin = 1;
            end else if (w == 16'hFFF0) begin
                if (addr == 255) begin
                    exp_done = 1; exp_end_lat = lat + DELAY_CYCLES; fin = 1;
                end else begin
                    addr++;
                    lat += DELAY_CYCLES + 2;
                end
            end else begin
                bit nk;
                exp_q.push_back('{w[15:8], w[7:0], lat});
                nk = (ni < nack_plan.size()) ? nack_plan[ni] : 1'b0;
                ni++;
                if (nk) begin
                    if (retry < MAX_RETRY) begin
                        retry++; lat = 1;
                    end else begin
                        exp_err = 1; exp_end_lat = 1; fin = 1;
                    end
                end else begin
                    if (exp_wc < 255) exp_wc++;
                    retry = 0;
                    if (addr == 255) begin
                        exp_done = 1; exp_end_lat = 1; fin = 1;
                    end else begin
                        addr++; lat = 3;
                    end
                end
            end
        end
        exp_addr = addr;
    endfunction

    task automatic load_rom(input int prog);
        for (int i = 0; i < 256; i++) rom_mem[i] = (prog == 3) ? 16'h0000 : 16'hFFFF;
        case (prog)
            0: begin rom_mem[0] = 16'h1280; rom_mem[1] = 16'hFFF0; rom_mem[2] = 16'h1214; rom_mem[3] = 16'hFFFF; end
            1: begin rom_mem[0] = 16'h1180; rom_mem[1] = 16'hFFFF; end
            2: begin rom_mem[0] = 16'h1280; rom_mem[1] = 16'h1180; rom_mem[2] = 16'hFFFF; end
            default: ;
        endcase
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic run_program(input int hold_fix, input int dly_fix, input bit rnd, input bit spam, input string tag);
        int   cyc = 0, last_evt = 0, pending = 0, hold = 0, ni = 0;
        bit   in_send = 0, prev_valid = 0, just_acc = 0, finished = 0;
        txn_t cur = '{8'd0, 8'd0, 0};
        build_model();
        @(negedge clk);
        start = 1'b1;
        sccb_bus.sccb_ready = 1'b1;
        while (!finished && cyc < 20000) begin
            @(negedge clk);
            cyc++;
            start = 1'b0;
            if (cyc == 1) begin
                check({tag, " start_busy"}, busy, 1);
                check({tag, " start_done_clr"}, {done, error}, 0);
                check({tag, " start_count"}, write_count, 0);
                check({tag, " start_addr"}, rom_addr, 0);
            end
            if (just_acc) begin
                check({tag, " valid_drop"}, sccb_bus.sccb_valid, 0);
                just_acc = 0;
            end
            if (sccb_bus.sccb_valid && !prev_valid) begin
                if (exp_q.size() == 0) begin
                    check({tag, " extra_write"}, {sccb_bus.sccb_reg, sccb_bus.sccb_wdata}, 16'hFFFF);
                end else begin
                    cur = exp_q.pop_front();
                    in_send = 1;
                    hold = rnd ? int'($urandom_range(0, 4)) : hold_fix;
                    check({tag, " latency"}, cyc - last_evt, cur.lat);
                end
            end
            if (in_send) begin
                check({tag, " valid_hold"}, sccb_bus.sccb_valid, 1);
                check({tag, " reg_data"}, {sccb_bus.sccb_reg, sccb_bus.sccb_wdata}, {cur.r, cur.d});
            end
            prev_valid = sccb_bus.sccb_valid;
            if (done || error) begin
                check({tag, " end_flags"}, {done, error, busy}, {exp_done, exp_err, 1'b0});
                check({tag, " end_count"}, write_count, exp_wc);
                check({tag, " end_addr"}, rom_addr, exp_addr);
                check({tag, " end_latency"}, cyc - last_evt, exp_end_lat);
                check({tag, " writes_left"}, exp_q.size(), 0);
                finished = 1;
            end
            sccb_bus.sccb_done = 1'b0;
            sccb_bus.sccb_nack = 1'b0;
            if (pending > 0) begin
                pending--;
                if (pending == 0) begin
                    sccb_bus.sccb_done = 1'b1;
                    sccb_bus.sccb_nack = (ni < nack_plan.size()) ? nack_plan[ni] : 1'b0;
                    ni++;
                    last_evt = cyc;
                end
            end
            if (in_send) begin
                if (hold > 0) begin
                    sccb_bus.sccb_ready = 1'b0;
                    hold--;
                end else begin
                    sccb_bus.sccb_ready = 1'b1;
                    in_send  = 0;
                    just_acc = 1;
                    pending  = rnd ? int'($urandom_range(1, 12)) : dly_fix;
                end
            end else begin
                sccb_bus.sccb_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            end
            if (spam && busy && !finished && (cyc % 5 == 2)) start = 1'b1;
        end
        start = 1'b0;
        sccb_bus.sccb_done = 1'b0;
        sccb_bus.sccb_nack = 1'b0;
        if (!finished) check({tag, " timeout"}, 0, 1);
    endtask

    typedef struct {
        int         prog;
        int         hold;
        int         ddly;
        logic [7:0] nacks;
        int         nnack;
        bit         rst;
        bit         spam;
        bit         e_done;
        bit         e_err;
        int         e_wc;
        int         e_addr;
    } vec_t;

    vec_t vecs[7];

    initial begin
        reset = 1'b1;
        start = 1'b0;
        sccb_bus.sccb_ready = 1'b0;
        sccb_bus.sccb_done  = 1'b0;
        sccb_bus.sccb_nack  = 1'b0;
        load_rom(0);

        vecs[0] = '{0, 0, 20, 8'b0000_0000, 0, 1, 0, 1, 0,   2,   3};
        vecs[1] = '{0, 5,  3, 8'b0000_0000, 0, 0, 1, 1, 0,   2,   3};
        vecs[2] = '{1, 0,  4, 8'b0000_0001, 1, 1, 0, 1, 0,   1,   1};
        vecs[3] = '{1, 2,  4, 8'b0000_1111, 4, 0, 0, 0, 1,   0,   0};
        vecs[4] = '{2, 0,  2, 8'b0001_1110, 5, 1, 1, 0, 1,   1,   1};
        vecs[5] = '{2, 1,  2, 8'b0000_0000, 0, 0, 0, 1, 0,   2,   2};
        vecs[6] = '{3, 0,  2, 8'b0000_0000, 0, 1, 0, 1, 0, 255, 255};

        repeat (2) @(negedge clk);
        check("reset_outputs", {busy, done, error, sccb_bus.sccb_valid}, 0);
        check("reset_addr_count", {rom_addr, write_count}, 0);
        check("reset_reg_data", {sccb_bus.sccb_reg, sccb_bus.sccb_wdata}, 0);
        reset = 1'b0;

        for (int v = 0; v < 7; v++) begin
            string tag;
            tag = $sformatf("vec%0d", v);
            load_rom(vecs[v].prog);
            nack_plan.delete();
            for (int i = 0; i < vecs[v].nnack; i++) nack_plan.push_back(vecs[v].nacks[i]);
            if (vecs[v].rst) do_reset();
            run_program(vecs[v].hold, vecs[v].ddly, 1'b0, vecs[v].spam, tag);
            check({tag, " table_status"}, {done, error}, {vecs[v].e_done, vecs[v].e_err});
            check({tag, " table_count"}, write_count, vecs[v].e_wc);
            check({tag, " table_addr"}, rom_addr, vecs[v].e_addr);
        end

        // reset while WAIT: outputs clear, a late sccb_done is ignored, restart replays
        begin
            int  n = 0;
            load_rom(0);
            nack_plan.delete();
            do_reset();
            sccb_bus.sccb_ready = 1'b1;
            start = 1'b1;
            @(negedge clk);
            start = 1'b0;
            while (!sccb_bus.sccb_valid && n < 20) begin
                @(negedge clk);
                n++;
            end
            check("rw_valid_seen", sccb_bus.sccb_valid, 1);
            repeat (3) @(negedge clk);
            check("rw_in_wait", {sccb_bus.sccb_valid, busy}, 2'b01);
            reset = 1'b1;
            @(negedge clk);
            reset = 1'b0;
            check("rw_flags_zero", {busy, done, error, sccb_bus.sccb_valid}, 0);
            check("rw_addr_count_zero", {rom_addr, write_count}, 0);
            check("rw_reg_data_zero", {sccb_bus.sccb_reg, sccb_bus.sccb_wdata}, 0);
            sccb_bus.sccb_done = 1'b1;
            @(negedge clk);
            sccb_bus.sccb_done = 1'b0;
            repeat (4) begin
                @(negedge clk);
                check("rw_late_done_ignored", {busy, sccb_bus.sccb_valid, write_count, rom_addr}, 0);
            end
            run_program(0, 6, 1'b0, 1'b0, "rw_replay");
        end

        for (int r = 0; r < 10; r++) begin
            int n;
            string tag;
            tag = $sformatf("rand%0d", r);
            for (int i = 0; i < 256; i++) rom_mem[i] = 16'hFFFF;
            n = $urandom_range(1, 10);
            for (int i = 0; i < n; i++) begin
                if ($urandom_range(0, 4) == 0) rom_mem[i] = 16'hFFF0;
                else rom_mem[i] = {8'($urandom_range(0, 254)), 8'($urandom)};
            end
            nack_plan.delete();
            for (int i = 0; i < 40; i++) nack_plan.push_back($urandom_range(0, 3) == 0);
            if ($urandom_range(0, 1) == 1) do_reset();
            run_program(0, 1, 1'b1, 1'($urandom_range(0, 1)), tag);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
